prio_arbiter4: RTL

Four-requester arbiter that shares a single downstream resource among requesters D0..D3, using the team's 4-to-2 priority encoding (D3 highest, D0 lowest) as its arbitration core. It adds grant holding, a hold-time limit with forced release, a starvation guard and a one-cycle turnaround between owners. It sits between requesting blocks and the shared resource; exactly one requester owns the resource at any time.

---
 rtl/prio_arbiter4.sv | 86 ++++++++
 1 files changed

// File: rtl/prio_arbiter4.sv
// prio_arbiter4: four-requester priority arbiter with grant hold, forced release, starvation guard and turnaround
module prio_arbiter4 #(
    parameter int HOLD_MAX   = 16,
    parameter int STARVE_LIM = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t     state;
    logic [7:0] hold;
    logic [3:0] mask;
    logic [3:0] age [4];
    logic [3:0] elig, starved, pick, win_oh;
    logic [1:0] win;
    logic       granting, normal_rel, forced_rel;
    // Starved requesters preempt plain priority; within each set the highest index wins.
    always_comb begin
        elig = req & ~mask;
        for (int i = 0; i < 4; i++) starved[i] = elig[i] && (age[i] == 4'(STARVE_LIM));
        pick       = |starved ? starved : elig;
        win        = pick[3] ? 2'd3 : pick[2] ? 2'd2 : pick[1] ? 2'd1 : 2'd0;
        win_oh     = 4'b0001 << win;
        granting   = (state == IDLE) && |elig;
        normal_rel = (state == GRANT) && !req[gnt_id];
        forced_rel = (state == GRANT) && req[gnt_id] && (hold == 8'(HOLD_MAX - 1));
    end
    // Arbitration FSM with registered grant outputs; normal release takes precedence over the hold limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            hold      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: if (granting) begin
                    state     <= GRANT;
                    gnt       <= win_oh;
                    gnt_id    <= win;
                    gnt_valid <= 1'b1;
                    busy      <= 1'b1;
                    hold      <= '0;
                end
                GRANT: if (normal_rel || forced_rel) begin
                    state     <= RELEASE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    timeout   <= forced_rel;
                end else begin
                    hold <= hold + 8'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    // A timed-out owner stays masked until it lets go of its request at least once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask <= '0;
        else        mask <= (mask & req) | (forced_rel ? gnt : 4'b0000);
    end
    // Wait counters age only unmasked, ungranted requesters and saturate at the starvation limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (!req[i] || mask[i] || gnt[i] || (granting && win_oh[i])) age[i] <= '0;
                else if (age[i] != 4'(STARVE_LIM)) age[i] <= age[i] + 4'd1;
        end
    end
endmodule
